// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle RV32I sequencer: fetches over the shared memory port, decodes the
// opcode class from the latched instruction and drives datapath write strobes and traps.
module cpu_seq_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        run_i,
  output logic        mem_req_o,
  output logic        mem_ifetch_o,
  output logic        mem_we_o,
  output logic [1:0]  mem_size_o,
  input  logic        mem_ack_i,
  input  logic [31:0] instr_i,
  output logic [31:0] ir_o,
  input  logic        branch_taken_i,
  output logic        pc_we_o,
  output logic [1:0]  pc_sel_o,
  output logic        rf_we_o,
  output logic [1:0]  wb_sel_o,
  output logic        csr_we_o,
  output logic        trap_o,
  output logic [3:0]  trap_cause_o,
  output logic        retire_o,
  output logic        busy_o
);

  localparam int unsigned CW = $clog2(TIMEOUT + 2);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_MISC   = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     ir_q, ir_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      cause_q, cause_d;

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic       is_lui, is_auipc, is_jal, is_jalr, is_branch, is_load, is_store;
  logic       is_opimm, is_op, is_csr, writes_rd, rd_nz, rs1_nz;
  logic       dec_legal, timeout_hit;
  logic [3:0] dec_cause;

  assign opcode    = ir_q[6:0];
  assign funct3    = ir_q[14:12];
  assign funct7    = ir_q[31:25];
  assign rd_nz     = (ir_q[11:7] != 5'd0);
  assign rs1_nz    = (ir_q[19:15] != 5'd0);
  assign is_lui    = (opcode == OPC_LUI);
  assign is_auipc  = (opcode == OPC_AUIPC);
  assign is_jal    = (opcode == OPC_JAL);
  assign is_jalr   = (opcode == OPC_JALR);
  assign is_branch = (opcode == OPC_BRANCH);
  assign is_load   = (opcode == OPC_LOAD);
  assign is_store  = (opcode == OPC_STORE);
  assign is_opimm  = (opcode == OPC_OPIMM);
  assign is_op     = (opcode == OPC_OP);
  assign is_csr    = (opcode == OPC_SYSTEM) && (funct3[1:0] != 2'b00);
  assign writes_rd = is_lui | is_auipc | is_jal | is_jalr | is_load | is_opimm | is_op | is_csr;

  // An ack arriving in the cycle the counter would reach TIMEOUT takes priority.
  assign timeout_hit = (TIMEOUT != 0) && !mem_ack_i && (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    dec_legal = 1'b0;
    dec_cause = 4'd2;
    case (opcode)
      OPC_LUI, OPC_AUIPC, OPC_JAL: dec_legal = 1'b1;
      OPC_JALR:   dec_legal = (funct3 == 3'b000);
      OPC_BRANCH: dec_legal = (funct3 != 3'b010) && (funct3 != 3'b011);
      OPC_LOAD:   dec_legal = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
      OPC_STORE:  dec_legal = (funct3 <= 3'b010);
      OPC_OPIMM: begin
        case (funct3)
          3'b001:  dec_legal = (funct7 == 7'd0);
          3'b101:  dec_legal = (funct7 == 7'd0) || (funct7 == F7_ALT);
          default: dec_legal = 1'b1;
        endcase
      end
      OPC_OP: dec_legal = (funct7 == 7'd0) ||
                          ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
      OPC_MISC: dec_legal = (funct3[2:1] == 2'b00);
      OPC_SYSTEM: begin
        if (ir_q == 32'h0000_0073)      dec_cause = 4'd11;
        else if (ir_q == 32'h0010_0073) dec_cause = 4'd3;
        else                            dec_legal = is_csr;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    ir_d         = ir_q;
    cnt_d        = '0;
    cause_d      = cause_q;
    mem_req_o    = 1'b0;
    mem_ifetch_o = 1'b0;
    mem_we_o     = 1'b0;
    mem_size_o   = 2'd0;
    pc_we_o      = 1'b0;
    pc_sel_o     = 2'd0;
    rf_we_o      = 1'b0;
    wb_sel_o     = 2'd0;
    csr_we_o     = 1'b0;
    trap_o       = 1'b0;
    retire_o     = 1'b0;
    case (state_q)
      S_IDLE: if (run_i) state_d = S_FETCH;
      S_FETCH: begin
        mem_req_o    = 1'b1;
        mem_ifetch_o = 1'b1;
        mem_size_o   = 2'd2;
        if (mem_ack_i) begin
          ir_d    = instr_i;
          state_d = S_DECODE;
        end else if (timeout_hit) begin
          cause_d = 4'd1;
          state_d = S_TRAP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DECODE: begin
        if (dec_legal) begin
          state_d = S_EXEC;
        end else begin
          cause_d = dec_cause;
          state_d = S_TRAP;
        end
      end
      S_EXEC: state_d = (is_load || is_store) ? S_MEM : S_WB;
      S_MEM: begin
        mem_req_o  = 1'b1;
        mem_we_o   = is_store;
        mem_size_o = ir_q[13:12];
        if (mem_ack_i) begin
          state_d = S_WB;
        end else if (timeout_hit) begin
          cause_d = is_store ? 4'd7 : 4'd5;
          state_d = S_TRAP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WB: begin
        rf_we_o  = writes_rd && rd_nz;
        if (is_load)                wb_sel_o = 2'd1;
        else if (is_jal || is_jalr) wb_sel_o = 2'd2;
        else if (is_csr)            wb_sel_o = 2'd3;
        csr_we_o = is_csr && ((funct3[1:0] == 2'b01) || rs1_nz);
        pc_we_o  = 1'b1;
        if (is_jal || (is_branch && branch_taken_i)) pc_sel_o = 2'd1;
        else if (is_jalr)                            pc_sel_o = 2'd2;
        retire_o = 1'b1;
        state_d  = run_i ? S_FETCH : S_IDLE;
      end
      S_TRAP: begin
        trap_o   = 1'b1;
        pc_we_o  = 1'b1;
        pc_sel_o = 2'd3;
        state_d  = run_i ? S_FETCH : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
      cnt_q   <= '0;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
    end
  end

  assign ir_o         = ir_q;
  assign trap_cause_o = cause_q;
  assign busy_o       = (state_q != S_IDLE);

endmodule
